// File: rtl/tt_pattern_pkg.sv
// Shared constants for the serial pattern detector: parameter defaults, ui_in bit map,
// match-mode encoding and the effective-length clamp.
package tt_pattern_pkg;

  localparam int         MAX_LEN_DEF       = 8;
  localparam int         CNT_W_DEF         = 4;
  localparam logic [7:0] RESET_PATTERN_DEF = 8'h07;

  localparam int UI_DIN     = 0;
  localparam int UI_VALID   = 1;
  localparam int UI_LOAD    = 2;
  localparam int UI_LEN_LO  = 3;
  localparam int UI_LEN_HI  = 5;
  localparam int UI_OVERLAP = 6;
  localparam int UI_MODE    = 7;

  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

  // Requested length len_m1+1, limited to what the history window can hold.
  function automatic logic [3:0] clamp_len(input logic [2:0] len_m1, input int max_len);
    logic [3:0] req;
    req = {1'b0, len_m1} + 4'd1;
    if (int'(req) > max_len) return 4'(max_len);
    return req;
  endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Bit history, fill tracking and windowed compare against the stored pattern.
// hit is combinational on the accepted bit; armed follows the registered fill level.
module pattern_matcher #(
  parameter int MAX_LEN = 8,
  parameter int FW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accept,
  input  logic               clear,
  input  logic               din,
  input  logic [FW-1:0]      len,
  input  logic               overlap,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit,
  output logic               armed
);

  localparam logic [FW-1:0] MAX_FILL = FW'(MAX_LEN);

  logic [MAX_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [FW:0]        fill_inc;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               bits_equal;

  // Only the newest L bits of {hist, din} take part in the compare.
  assign window = {hist, din};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign fill_inc   = {1'b0, fill} + (FW + 1)'(1);
  assign bits_equal = (((window ^ pattern) & mask) == '0);
  assign hit        = accept && (fill_inc >= {1'b0, len}) && bits_equal;
  assign armed      = (fill >= len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= window[MAX_LEN-2:0];
      // Without overlap a match consumes its bits, so counting restarts from zero.
      if (hit && !overlap) begin
        fill <= '0;
      end else if (fill != MAX_FILL) begin
        fill <= fill_inc[FW-1:0];
      end
    end
  end

endmodule

// File: rtl/tt_um_pattern_detector.sv
// Serial pattern detector: Mealy match same cycle as the bit, Moore match one cycle later.
// No backpressure; ena=0 freezes every register and suppresses the Mealy output.
module tt_um_pattern_detector
  import tt_pattern_pkg::*;
#(
  parameter int         MAX_LEN       = MAX_LEN_DEF,
  parameter logic [7:0] RESET_PATTERN = RESET_PATTERN_DEF,
  parameter int         CNT_W         = CNT_W_DEF
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int FW = $clog2(MAX_LEN + 1);

  logic               din;
  logic               din_valid;
  logic               load;
  logic               overlap;
  mode_e              mode;
  logic [FW-1:0]      len;
  logic               accept;
  logic               clear;
  logic               hit;
  logic               armed;
  logic               match;
  logic               moore_q;
  logic [MAX_LEN-1:0] pattern;
  logic [CNT_W-1:0]   match_cnt;
  logic [3:0]         cnt_pin;

  assign din       = ui_in[UI_DIN];
  assign din_valid = ui_in[UI_VALID];
  assign load      = ui_in[UI_LOAD];
  assign overlap   = ui_in[UI_OVERLAP];
  assign mode      = mode_e'(ui_in[UI_MODE]);
  assign len       = FW'(clamp_len(ui_in[UI_LEN_HI:UI_LEN_LO], MAX_LEN));

  // A load in the same cycle as a valid bit wins; the bit is dropped.
  assign accept = ena && din_valid && !load;
  assign clear  = ena && load;

  pattern_matcher #(
    .MAX_LEN (MAX_LEN),
    .FW      (FW)
  ) u_matcher (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (accept),
    .clear   (clear),
    .din     (din),
    .len     (len),
    .overlap (overlap),
    .pattern (pattern),
    .hit     (hit),
    .armed   (armed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= RESET_PATTERN[MAX_LEN-1:0];
    end else if (clear) begin
      pattern <= uio_in[MAX_LEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clear) begin
      match_cnt <= '0;
    end else if (hit) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  // Pulse is armed only by Moore-mode hits, so a later mode switch still lets it finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moore_q <= 1'b0;
    end else if (ena) begin
      moore_q <= !load && hit && (mode == MODE_MOORE);
    end
  end

  assign match = (hit && (mode == MODE_MEALY)) || moore_q;

  generate
    if (CNT_W >= 4) begin : g_cnt_wide
      assign cnt_pin = match_cnt[3:0];
    end else begin : g_cnt_narrow
      assign cnt_pin = {{(4 - CNT_W){1'b0}}, match_cnt};
    end
  endgenerate

  assign uo_out  = rst_n ? {cnt_pin, 2'b00, armed, match} : 8'h00;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_pattern_detector.sv
// Bench for tt_um_pattern_detector: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a bit-list reference model.
module tb_tt_um_pattern_detector;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b0;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_pattern_detector dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted bit since the last clear, kept as a plain list.
  logic [7:0] m_pat;
  bit         m_q[$];
  int         m_fill;
  int         m_cnt;
  bit         m_moore;
  logic       obs_match;
  logic [7:0] obs_uo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat   = 8'h07;
    m_q.delete();
    m_fill  = 0;
    m_cnt   = 0;
    m_moore = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, compare mid-low-phase, advance the model.
  task automatic cycle(input logic e, input logic v, input logic d, input logic ld,
                       input int lm1, input logic ov, input logic md, input logic [7:0] u);
    int         len;
    int         n;
    bit         acc;
    bit         hit;
    bit         b;
    logic [7:0] exp_uo;
    @(negedge clk);
    ena    = e;
    uio_in = u;
    ui_in  = {md, ov, 3'(lm1), ld, v, d};
    len    = (lm1 + 1 > 8) ? 8 : lm1 + 1;
    acc    = e && v && !ld;
    hit    = 1'b0;
    if (acc && (m_fill + 1 >= len)) begin
      hit = 1'b1;
      n   = m_q.size();
      for (int j = 0; j < len; j++) begin
        b = (j == len - 1) ? d : m_q[n - (len - 1) + j];
        if (b != m_pat[len - 1 - j]) hit = 1'b0;
      end
    end
    exp_uo = {4'(m_cnt), 2'b00, 1'(m_fill >= len), 1'((hit && !md) || m_moore)};
    #2;
    chk("uo_out", 32'(uo_out), 32'(exp_uo));
    chk("uio_pins", 32'({uio_out, uio_oe}), 32'h0);
    obs_match = uo_out[0];
    obs_uo    = uo_out;
    if (e) begin
      if (ld) begin
        m_pat = u;
        m_q.delete();
        m_fill  = 0;
        m_cnt   = 0;
        m_moore = 1'b0;
      end else begin
        m_moore = hit && md;
        if (acc) begin
          m_q.push_back(d);
          if (m_q.size() > 16) void'(m_q.pop_front());
          m_fill = (hit && !ov) ? 0 : ((m_fill < 8) ? m_fill + 1 : 8);
          m_cnt  = (m_cnt + int'(hit)) % 16;
        end
      end
    end
  endtask

  // Load a pattern, feed bits (first bit in the MSB of the used range), then idle cycles.
  task automatic run_seq(input int lm1, input logic ov, input logic md, input logic [7:0] pat,
                         input logic [31:0] bits, input int nbits, input int tail,
                         output logic [31:0] mvec);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, lm1, ov, md, pat);
    mvec = '0;
    for (int i = 0; i < nbits; i++) begin
      cycle(1'b1, 1'b1, bits[nbits - 1 - i], 1'b0, lm1, ov, md, pat);
      mvec[i] = obs_match;
    end
    for (int i = 0; i < tail; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, lm1, ov, md, pat);
      mvec[nbits + i] = obs_match;
    end
  endtask

  initial begin
    logic [31:0] mv;
    logic        e;
    logic        v;
    logic        d;
    logic        ld;
    logic [7:0]  u;
    int          lm1;
    logic        ov;
    logic        md;

    model_reset();
    #3;
    chk("reset_uo", 32'(uo_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pattern 111, L=3, Mealy, overlap: hits on bits 3, 4, 5.
    mv = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 8'h00);
      mv[i] = obs_match;
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h00);
    chk("ovl_matches", mv, 32'h1C);
    chk("ovl_count", 32'(obs_uo[7:4]), 32'd3);

    // No overlap: hits on bits 3 and 6 only.
    run_seq(2, 1'b0, 1'b0, 8'h07, 32'b111111, 6, 1, mv);
    chk("noovl_matches", mv, 32'h24);
    chk("noovl_count", 32'(obs_uo[7:4]), 32'd2);

    // Moore, pattern 1101: pulses the cycle after bits 4 and 7.
    run_seq(3, 1'b1, 1'b1, 8'h0D, 32'b1101101, 7, 1, mv);
    chk("moore_matches", mv, 32'h90);
    run_seq(3, 1'b1, 1'b1, 8'h0D, 32'b1101101, 7, 2, mv);
    chk("moore_count", 32'(obs_uo[7:4]), 32'd2);

    // Load alongside a valid bit after two accepted bits clears everything.
    run_seq(2, 1'b1, 1'b0, 8'h07, 32'b11, 2, 0, mv);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 8'h07);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h07);
    chk("load_count", 32'(obs_uo[7:4]), 32'd0);
    chk("load_armed", 32'(obs_uo[1]), 32'd0);
    mv = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 8'h07);
      mv[i] = obs_match;
    end
    chk("load_refill", mv, 32'h4);

    // 17 hits with L=2, pattern 11: counter wraps to 1.
    run_seq(1, 1'b1, 1'b0, 8'h03, 32'h3FFFF, 18, 1, mv);
    chk("wrap_matches", mv, 32'h3FFFE);
    chk("wrap_count", 32'(obs_uo[7:4]), 32'd1);

    // ena low with toggling valid: outputs hold count=1, armed=1, match=0.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'(i % 2), 1'b1, 1'b0, 1, 1'b1, 1'b0, 8'h03);
      chk("ena_hold", 32'(obs_uo), 32'h12);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'h03);
    chk("ena_resume", 32'(obs_uo), 32'h12);

    // Asynchronous reset mid-cycle, then the reset pattern (111) must be back.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_uo", 32'(uo_out), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mv = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 8'h00);
      mv[i] = obs_match;
    end
    chk("reset_pattern", mv, 32'h4);

    // Randomized traffic with slowly changing configuration.
    lm1 = 2;
    ov  = 1'b1;
    md  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        lm1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
      if ($urandom_range(0, 29) == 0) ov = ~ov;
      if ($urandom_range(0, 29) == 0) md = ~md;
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 9) < 7);
      ld = ($urandom_range(0, 39) == 0);
      d  = 1'($urandom_range(0, 1));
      u  = 8'($urandom_range(0, 255));
      cycle(e, v, d, ld, lm1, ov, md, u);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_pattern_detector.md
TT_UM_PATTERN_DETECTOR -- requirements
Module: tt_um_pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..8.
REQ-002 Parameter RESET_PATTERN, default 8'h07: pattern register value after reset.
REQ-003 Parameter CNT_W, default 4: match-counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  design enable; low freezes all state.
REQ-007 ui_in  input  8  [0] din, [1] din_valid, [2] load, [5:3] len_m1 (pattern length minus 1), [6] overlap enable, [7] mode (0 = Mealy, 1 = Moore).
REQ-008 uio_in  input  8  pattern value captured on load; pattern[L-1] is the first bit of the sequence, pattern[0] the last.
REQ-009 uo_out  output  8  [0] match, [1] armed, [3:2] 2'b00, [7:4] match count.
REQ-010 uio_out  output  8  constant 8'h00.
REQ-011 uio_oe  output  8  constant 8'h00; all bidirectional pins are inputs.

Function
REQ-012 L SHALL be min(len_m1+1, MAX_LEN); len_m1, overlap and mode are sampled every cycle as static configuration.
REQ-013 An accepted bit is a cycle with ena=1, din_valid=1 and load=0.
REQ-014 Shift: hist <= {hist[MAX_LEN-2:0], din}, so hist[0] is the newest bit.
REQ-015 fill counts accepted bits, saturates at MAX_LEN, and is 0..MAX_LEN wide.
REQ-016 A hit occurs on an accepted bit when fill+1 >= L and {hist,din}[L-1:0] == pattern[L-1:0].
REQ-017 Mealy (mode=0): match = hit, combinational in the same cycle as the accepted bit; 0 in all other cycles.
REQ-018 Moore (mode=1): match is registered; it is 1 for exactly the one cycle after a hit and 0 otherwise.
REQ-019 Overlap=1: fill continues after a hit, so trailing bits may begin a new match.
REQ-020 Overlap=0: fill <= 0 on a hit; the next match needs L fresh bits.
REQ-021 armed = (fill >= L), registered.
REQ-022 Each hit increments the CNT_W-bit match count modulo 2^CNT_W; it wraps and does not saturate.
REQ-023 load=1 with ena=1: pattern <= uio_in, and hist, fill, match count and Moore match register are all cleared. The din bit in that cycle is discarded, so load wins over din_valid.
REQ-024 A change of L mid-stream takes effect on the next accepted bit, with no flush; fill is reused against the new L.
REQ-025 ena=0: no state changes, and the Mealy match is forced to 0.
REQ-026 A mode change mid-stream SHALL NOT corrupt the count; a pending Moore pulse completes.

Reset
REQ-027 While rst_n=0, registers reset asynchronously to: pattern=RESET_PATTERN, hist=0, fill=0, match count=0, Moore match=0.
REQ-028 While rst_n=0, uo_out=8'h00.
REQ-029 Reset deassertion takes effect on the next clk edge; the first accepted bit after reset is counted.

Structure
REQ-030 Shared package tt_pattern_pkg holds:
- MAX_LEN and CNT_W defaults;
- RESET_PATTERN;
- ui_in field bit-position constants;
- mode encoding constants MODE_MEALY=0 and MODE_MOORE=1.
REQ-031 Sub-module pattern_matcher holds hist, fill and the compare, and outputs hit and armed. The top level holds the pattern register, the match counter, the Moore register and the pin mapping.
REQ-032 The implementation SHALL use no latches and no logic on clock or reset paths.

Verification
REQ-033 Reset, then L=3, Mealy, overlap=1, pattern 3'b111, stream 1,1,1,1,1 -> match on bits 3, 4 and 5; count=3.
REQ-034 Same setup with overlap=0, stream 1,1,1,1,1,1 -> match on bits 3 and 6 only; count=2.
REQ-035 Load uio_in=8'h0D, L=4 (pattern 1101), Moore, overlap=1, stream 1,1,0,1,1,0,1 -> match high the cycle after bits 4 and 7; count=2.
REQ-036 Load asserted together with din_valid=1 after 2 accepted bits -> count=0, armed=0, fill=0; that bit is not shifted in.
REQ-037 17 hits with L=2, pattern 2'b11, overlap=1 -> count wraps to 1.
REQ-038 Assert rst_n=0 mid-stream, asynchronous to clk -> uo_out=0 immediately and pattern=8'h07.
REQ-039 Hold ena=0 while din_valid toggles -> no state change, and match stays 0.
